// File: rtl/regfile_dump_reader.sv
// Streams a wrapping register-file address range out as {addr, data} words on valid/ready,
// one word per two cycles at best, keeping a running XOR checksum of accepted words.
module regfile_dump_reader #(
  parameter int ASIZE = 5,
  parameter int DSIZE = 32,
  parameter int NREG  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [ASIZE-1:0] first_addr,
  input  logic [ASIZE-1:0] last_addr,
  output logic [ASIZE-1:0] raddr,
  input  logic [DSIZE-1:0] rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ASIZE-1:0] out_addr,
  output logic [DSIZE-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic [DSIZE-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  localparam logic [ASIZE-1:0] LAST_IDX = ASIZE'(NREG - 1);

  state_t           state;
  logic [ASIZE-1:0] cur_addr;
  logic [ASIZE-1:0] last_q;
  logic [ASIZE-1:0] next_addr;

  assign raddr     = cur_addr;
  assign next_addr = (cur_addr == LAST_IDX) ? '0 : cur_addr + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      last_q    <= '0;
      out_addr  <= '0;
      out_data  <= '0;
      checksum  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cur_addr <= first_addr;
            last_q   <= last_addr;
            checksum <= '0;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            // rdata here is the pre-edge regfile value, so a same-edge write is not seen
            out_data  <= rdata;
            out_addr  <= cur_addr;
            out_valid <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (abort) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (out_ready) begin
            checksum  <= checksum ^ out_data;
            out_valid <= 1'b0;
            if (out_addr == last_q) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              cur_addr <= next_addr;
              state    <= LOAD;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: regfile model, vector table, corner sequences, random dumps.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  first_addr = '0;
  logic [4:0]  last_addr = '0;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  logic [31:0] rf [32];
  logic [31:0] shadow [32];
  logic        we = 1'b0;
  logic [4:0]  wa = '0;
  logic [31:0] wd = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (we) rf[wa] <= wd;
  assign rdata = rf[raddr];

  regfile_dump_reader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .first_addr(first_addr), .last_addr(last_addr),
    .raddr(raddr), .rdata(rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done), .checksum(checksum)
  );

  typedef struct {
    logic [4:0]  f;
    logic [4:0]  l;
    int          pct;
    int          words;
    logic [31:0] ck;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    tick();
    we = 1'b0;
    shadow[a] = d;
  endtask

  // Run one dump; every word is checked against the expected wrapping address order and shadow data.
  task automatic do_dump(input logic [4:0] f, input logic [4:0] l, input int pct,
                         output int got, output logic [31:0] ck);
    int dones = 0;
    int cyc = 0;
    logic [4:0] ea;
    got = 0;
    first_addr = f; last_addr = l; start = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0; first_addr = 5'($urandom); last_addr = 5'($urandom);
    chk("lat_busy", busy, 1);
    chk("lat_valid_lo", out_valid, 0);
    tick();
    chk("lat_valid_hi", out_valid, 1);
    while (dones == 0 && cyc < 400) begin
      out_ready = (int'($urandom_range(99)) < pct);
      if (out_valid && out_ready) begin
        ea = f + 5'(got);
        chk("word_addr", out_addr, ea);
        chk("word_data", out_data, shadow[ea]);
        got++;
      end
      tick();
      cyc++;
      if (done) dones++;
    end
    out_ready = 1'b0;
    chk("done_seen", dones, 1);
    ck = checksum;
    tick();
    chk("done_once", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vecs [6];
    int          got;
    logic [31:0] ck;
    logic [31:0] exp_ck;
    int          n;
    logic [4:0]  f, l;

    vecs[0] = '{5'd0,  5'd3,  100, 4,  32'h0000_000B};
    vecs[1] = '{5'd30, 5'd1,  100, 4,  32'h6042_0004};
    vecs[2] = '{5'd1,  5'd1,  50,  1,  32'h0000_0005};
    vecs[3] = '{5'd31, 5'd0,  70,  2,  32'hBEEF_0031};
    vecs[4] = '{5'd0,  5'd31, 60,  32, 32'h6042_000A};
    vecs[5] = '{5'd2,  5'd2,  30,  1,  32'h0000_0007};

    // Preload the regfile while the DUT is held in reset
    rst = 1'b1;
    for (int i = 0; i < 32; i++) wr(5'(i), 32'h0);
    wr(5'd1, 32'd5); wr(5'd2, 32'd7); wr(5'd3, 32'd9);
    wr(5'd30, 32'hDEAD_0030); wr(5'd31, 32'hBEEF_0031);
    rst = 1'b0;
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_checksum", checksum, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_data", out_data, 0);

    for (int i = 0; i < 6; i++) begin
      do_dump(vecs[i].f, vecs[i].l, vecs[i].pct, got, ck);
      chk($sformatf("vec%0d_words", i), got, vecs[i].words);
      chk($sformatf("vec%0d_checksum", i), ck, vecs[i].ck);
    end

    // Single register with consumer stalled: word must hold steady
    first_addr = 5'd1; last_addr = 5'd1; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_addr", out_addr, 1);
      chk("stall_data", out_data, 5);
      tick();
    end
    out_ready = 1'b1;
    tick(); out_ready = 1'b0;
    chk("stall_acc_valid", out_valid, 0);
    chk("stall_done", done, 1);
    chk("stall_checksum", checksum, 5);
    tick();
    chk("stall_done_drop", done, 0);

    // Abort while the second word is on offer
    first_addr = 5'd1; last_addr = 5'd3; start = 1'b1;
    tick(); start = 1'b0;
    tick(); out_ready = 1'b1;
    tick(); out_ready = 1'b0;
    tick();
    chk("abort_pre_addr", out_addr, 2);
    abort = 1'b1; out_ready = 1'b1;
    tick(); abort = 1'b0; out_ready = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_checksum", checksum, 5);
    tick();
    chk("abort_no_done", done, 0);
    do_dump(5'd0, 5'd3, 100, got, ck);
    chk("abort_restart_words", got, 4);
    chk("abort_restart_ck", ck, 32'h0000_000B);

    // Start while busy is ignored, then reset mid-dump
    first_addr = 5'd1; last_addr = 5'd3; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    first_addr = 5'd20; last_addr = 5'd20; start = 1'b1;
    tick(); start = 1'b0;
    chk("busy_start_addr", out_addr, 1);
    chk("busy_start_valid", out_valid, 1);
    out_ready = 1'b1;
    tick(); out_ready = 1'b0;
    tick();
    chk("busy_start_next", out_addr, 2);
    chk("busy_start_data", out_data, 7);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_checksum", checksum, 0);
    chk("mid_rst_out_addr", out_addr, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_raddr", raddr, 0);
    tick();
    chk("mid_rst_idle", busy, 0);

    // Regfile write on the LOAD edge is not observed
    first_addr = 5'd2; last_addr = 5'd2; start = 1'b1;
    tick(); start = 1'b0;
    we = 1'b1; wa = 5'd2; wd = 32'h55;
    tick(); we = 1'b0;
    chk("coh_same_edge", out_data, 7);
    out_ready = 1'b1;
    tick(); out_ready = 1'b0;
    tick();
    shadow[2] = 32'h55;
    wr(5'd2, 32'd7);
    // Write one cycle before the LOAD edge is observed
    first_addr = 5'd2; last_addr = 5'd2; start = 1'b1;
    we = 1'b1; wa = 5'd2; wd = 32'h55;
    tick(); start = 1'b0; we = 1'b0;
    tick();
    chk("coh_prior_edge", out_data, 32'h55);
    out_ready = 1'b1;
    tick(); out_ready = 1'b0;
    chk("coh_checksum", checksum, 32'h55);
    tick();
    shadow[2] = 32'h55;

    // Random contents and ranges against the wrapping-range reference
    for (int it = 0; it < 12; it++) begin
      for (int k = 0; k < 4; k++) wr(5'($urandom), $urandom);
      f = 5'($urandom);
      l = 5'($urandom);
      n = ((int'(l) - int'(f) + 32) % 32) + 1;
      exp_ck = '0;
      for (int k = 0; k < n; k++) exp_ck ^= shadow[(int'(f) + k) % 32];
      do_dump(f, l, int'($urandom_range(100, 30)), got, ck);
      chk($sformatf("rnd%0d_words", it), got, n);
      chk($sformatf("rnd%0d_checksum", it), ck, exp_ck);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
